// File: rtl/clkgen_pkg.sv
// Shared FSM states, per-channel configuration record and legality check for clkgen_multi_div.
// Config fields are sized for the widest supported CNT_W; narrower builds zero-extend into them.
package clkgen_pkg;

  localparam int CNT_W_MAX = 16;

  typedef enum logic [2:0] {
    RESET,
    ALIGN,
    SETTLE,
    LOCKED,
    RECONF
  } state_t;

  typedef struct packed {
    logic [CNT_W_MAX-1:0] div;
    logic [CNT_W_MAX-1:0] high;
    logic [CNT_W_MAX-1:0] phase;
  } chan_cfg_t;

  function automatic logic cfg_legal(input chan_cfg_t c);
    return (c.div >= CNT_W_MAX'(2)) && (c.high != '0) &&
           (c.high < c.div) && (c.phase < c.div);
  endfunction

endpackage

// File: rtl/clkgen_chan.sv
// One divided output: wrapping counter, phase-aligned reload, registered outclk (1 cycle after cnt).
// No backpressure; config writes and alignment are sequenced by the parent FSM. Strobe under CLKGEN_STROBE_EN.
module clkgen_chan
  import clkgen_pkg::*;
#(
  parameter chan_cfg_t DEF_CFG = '0
) (
  input  logic      refclk,
  input  logic      rst_n,
  input  logic      align,
  input  logic      run,
  input  logic      wr_en,
  input  chan_cfg_t wr_cfg,
  output logic      outclk
`ifdef CLKGEN_STROBE_EN
  ,
  output logic      stb
`endif
);

  localparam logic [CNT_W_MAX-1:0] ONE = CNT_W_MAX'(1);

  chan_cfg_t            cfg_q;
  logic [CNT_W_MAX-1:0] cnt_q;
  logic [CNT_W_MAX-1:0] align_cnt;
  logic                 last;
  logic                 high_now;

  // Starting phase cycles before zero makes the first rising edge lag by exactly 'phase'.
  assign align_cnt = (cfg_q.phase == '0) ? '0 : cfg_q.div - cfg_q.phase;
  assign last      = (cnt_q >= cfg_q.div - ONE);
  assign high_now  = (cnt_q < cfg_q.high);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q  <= DEF_CFG;
      cnt_q  <= '0;
      outclk <= 1'b0;
    end else begin
      if (wr_en) cfg_q <= wr_cfg;
      if (align)    cnt_q <= align_cnt;
      else if (run) cnt_q <= last ? '0 : cnt_q + ONE;
      outclk <= run & high_now;
    end
  end

`ifdef CLKGEN_STROBE_EN
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) stb <= 1'b0;
    else        stb <= run & high_now & ~outclk;
  end
`endif

endmodule

// File: rtl/clkgen_multi_div.sv
// NUM_CLOCKS integer-divided clocks from refclk with valid/ready reconfiguration and lock indication.
// cfg_ready only while LOCKED; a legal request re-aligns all channels. Optional strobes: CLKGEN_STROBE_EN.
module clkgen_multi_div
  import clkgen_pkg::*;
#(
  parameter int                          NUM_CLOCKS  = 2,
  parameter int                          CNT_W       = 8,
  parameter int                          LOCK_CYCLES = 16,
  parameter logic [NUM_CLOCKS*CNT_W-1:0] DEF_DIV     = {8'd4, 8'd10},
  parameter logic [NUM_CLOCKS*CNT_W-1:0] DEF_HIGH    = {8'd2, 8'd5},
  parameter logic [NUM_CLOCKS*CNT_W-1:0] DEF_PHASE   = {8'd0, 8'd0},
  localparam int                         CH_W        = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_chan,
  input  logic [CNT_W-1:0]      cfg_div,
  input  logic [CNT_W-1:0]      cfg_high,
  input  logic [CNT_W-1:0]      cfg_phase,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
`ifdef CLKGEN_STROBE_EN
  ,
  output logic [NUM_CLOCKS-1:0] outclk_stb
`endif
);

  localparam int SET_W = $clog2(LOCK_CYCLES + 1);

  state_t           state_q, state_d;
  logic [SET_W-1:0] settle_q;
  logic [CH_W-1:0]  pend_chan_q;
  chan_cfg_t        pend_cfg_q;
  chan_cfg_t        req;
  logic             chan_ok, req_ok, accept;
  logic             run, align;

  assign req     = '{div:   CNT_W_MAX'(cfg_div),
                     high:  CNT_W_MAX'(cfg_high),
                     phase: CNT_W_MAX'(cfg_phase)};
  assign chan_ok = (32'(cfg_chan) < NUM_CLOCKS);
  assign req_ok  = chan_ok & cfg_legal(req);
  assign accept  = cfg_valid & cfg_ready;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET:   state_d = ALIGN;
      ALIGN:   state_d = (LOCK_CYCLES > 1) ? SETTLE : LOCKED;
      SETTLE:  if (settle_q >= SET_W'(LOCK_CYCLES - 1)) state_d = LOCKED;
      LOCKED:  if (accept && req_ok) state_d = RECONF;
      RECONF:  state_d = ALIGN;
      default: state_d = RESET;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    run       = 1'b0;
    align     = 1'b0;
    case (state_q)
      ALIGN:   align = 1'b1;
      SETTLE:  run = 1'b1;
      LOCKED: begin
        run       = 1'b1;
        cfg_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // The ALIGN cycle counts as the first settle cycle.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q    <= '0;
      locked      <= 1'b0;
      cfg_err     <= 1'b0;
      pend_chan_q <= '0;
      pend_cfg_q  <= '0;
    end else begin
      if (state_q == ALIGN)       settle_q <= SET_W'(1);
      else if (state_q == SETTLE) settle_q <= settle_q + SET_W'(1);
      locked  <= (state_q == LOCKED);
      cfg_err <= accept & ~req_ok;
      if (accept && req_ok) begin
        pend_chan_q <= cfg_chan;
        pend_cfg_q  <= req;
      end
    end
  end

`ifdef CLKGEN_STROBE_EN
  logic [NUM_CLOCKS-1:0] stb_raw;
  assign outclk_stb = stb_raw & {NUM_CLOCKS{run}};
`endif

  for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
    // Leftmost field of each DEF_* concatenation belongs to channel 0.
    localparam int        OFS = (NUM_CLOCKS - 1 - g) * CNT_W;
    localparam chan_cfg_t DEF = '{div:   CNT_W_MAX'(DEF_DIV[OFS +: CNT_W]),
                                  high:  CNT_W_MAX'(DEF_HIGH[OFS +: CNT_W]),
                                  phase: CNT_W_MAX'(DEF_PHASE[OFS +: CNT_W])};

    clkgen_chan #(
      .DEF_CFG(DEF)
    ) u_chan (
      .refclk (refclk),
      .rst_n  (rst_n),
      .align  (align),
      .run    (run),
      .wr_en  ((state_q == RECONF) && (pend_chan_q == CH_W'(g))),
      .wr_cfg (pend_cfg_q),
      .outclk (outclk[g])
`ifdef CLKGEN_STROBE_EN
      ,
      .stb    (stb_raw[g])
`endif
    );
  end

endmodule

// File: tb/tb_clkgen_multi_div.sv
// Randomised reconfiguration of clkgen_multi_div checked every cycle against a timeline model.
module tb_clkgen_multi_div;

  localparam int NC = 3;
  localparam int LC = 16;
  localparam int DEF_D[NC] = '{4, 10, 7};
  localparam int DEF_H[NC] = '{2, 5, 3};
  localparam int DEF_P[NC] = '{0, 0, 1};

  logic          refclk    = 1'b0;
  logic          rst_n     = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [1:0]    cfg_chan  = '0;
  logic [7:0]    cfg_div   = '0;
  logic [7:0]    cfg_high  = '0;
  logic [7:0]    cfg_phase = '0;
  logic          cfg_ready, cfg_err, locked;
  logic [NC-1:0] outclk;
`ifdef CLKGEN_STROBE_EN
  logic [NC-1:0] outclk_stb;
`endif

  always #5 refclk = ~refclk;

  clkgen_multi_div #(
    .NUM_CLOCKS (NC),
    .CNT_W      (8),
    .LOCK_CYCLES(LC),
    .DEF_DIV    ({8'd4, 8'd10, 8'd7}),
    .DEF_HIGH   ({8'd2, 8'd5, 8'd3}),
    .DEF_PHASE  ({8'd0, 8'd0, 8'd1})
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_phase (cfg_phase),
    .cfg_err   (cfg_err),
    .outclk    (outclk),
    .locked    (locked)
`ifdef CLKGEN_STROBE_EN
    ,
    .outclk_stb(outclk_stb)
`endif
  );

  int checks = 0, failures = 0;

  // Model: cycle index since reset release, the ALIGN cycle of the current epoch,
  // a pending legal request (applied the cycle after RECONF) and a pending error pulse.
  int cyc = 0, t_align = 1, reconf_at = -1, err_at = -1;
  int m_div[NC], m_high[NC], m_phase[NC];
  int p_ch, p_div, p_high, p_phase;
  logic [NC-1:0] prev_eo = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic exp_out(input int i, input int t);
    int k;
    if (t < t_align + 2) return 1'b0;
    k = (t - t_align - 2 - m_phase[i]) % m_div[i];
    if (k < 0) k += m_div[i];
    return (k < m_high[i]);
  endfunction

  always @(negedge refclk) begin
    logic [NC-1:0] eo;
    logic er, el;
    if (!rst_n) begin
      cyc = 0; t_align = 1; reconf_at = -1; err_at = -1; prev_eo = '0;
      for (int i = 0; i < NC; i++) begin
        m_div[i] = DEF_D[i]; m_high[i] = DEF_H[i]; m_phase[i] = DEF_P[i];
      end
      chk("rst_outclk", 32'(outclk), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_ready", 32'(cfg_ready), 0);
      chk("rst_err", 32'(cfg_err), 0);
    end else begin
      cyc++;
      if (reconf_at >= 0 && cyc == reconf_at + 1) begin
        m_div[p_ch] = p_div; m_high[p_ch] = p_high; m_phase[p_ch] = p_phase;
        t_align = cyc;
        reconf_at = -1;
      end
      for (int i = 0; i < NC; i++) eo[i] = exp_out(i, cyc);
      er = (cyc >= t_align + LC) && (reconf_at < 0);
      el = (cyc >= t_align + LC + 1);
      chk("outclk", 32'(outclk), 32'(eo));
      chk("cfg_ready", 32'(cfg_ready), 32'(er));
      chk("locked", 32'(locked), 32'(el));
      chk("cfg_err", 32'(cfg_err), 32'(cyc == err_at));
`ifdef CLKGEN_STROBE_EN
      chk("outclk_stb", 32'(outclk_stb),
          32'(eo & ~prev_eo & {NC{(cyc > t_align) && (cyc != reconf_at)}}));
`endif
      prev_eo = eo;
      if (er && cfg_valid) begin
        if (cfg_chan < NC && cfg_div >= 2 && cfg_high >= 1 && cfg_high < cfg_div &&
            cfg_phase < cfg_div) begin
          reconf_at = cyc + 1;
          p_ch = int'(cfg_chan); p_div = int'(cfg_div);
          p_high = int'(cfg_high); p_phase = int'(cfg_phase);
        end else begin
          err_at = cyc + 1;
        end
      end
    end
  end

  task automatic at_cycle(input int n);
    int g = 0;
    while (cyc != n && g < 3000) begin
      @(negedge refclk); #1;
      g++;
    end
    if (cyc != n) chk("cycle_reached", 32'(cyc), 32'(n));
  endtask

  task automatic send(input int ch, input int d, input int h, input int p, output int acc);
    int waited = 0;
    @(posedge refclk); #1;
    cfg_valid = 1'b1;
    cfg_chan  = 2'(ch); cfg_div = 8'(d); cfg_high = 8'(h); cfg_phase = 8'(p);
    acc = -1;
    while (acc < 0 && waited < 300) begin
      @(negedge refclk); #1;
      if (cfg_ready) acc = cyc;
      else waited++;
    end
    if (acc < 0) chk("accept_timeout", 32'(waited), 0);
    @(posedge refclk); #1;
    cfg_valid = 1'b0;
  endtask

  // Hand-derived default timing (ch0 4/2/0, ch1 10/5/0, ch2 7/3/1).
  task automatic pin_defaults();
    at_cycle(2);      chk("pin_c2", 32'(outclk), 32'h0);
    at_cycle(3);      chk("pin_c3", 32'(outclk), 32'h3);
    at_cycle(4);      chk("pin_c4", 32'(outclk), 32'h7);
    at_cycle(5);      chk("pin_c5", 32'(outclk), 32'h6);
    at_cycle(7);      chk("pin_c7", 32'(outclk), 32'h3);
    at_cycle(8);      chk("pin_c8", 32'(outclk), 32'h1);
    at_cycle(LC);     chk("pin_ready_early", 32'(cfg_ready), 0);
    at_cycle(LC + 1); chk("pin_locked_early", 32'(locked), 0);
    at_cycle(LC + 2); chk("pin_locked", 32'(locked), 1);
  endtask

  initial begin
    int acc, acc2, a;
    int ch, d, h, p;
    repeat (3) @(negedge refclk);
    #1 rst_n = 1'b1;
    pin_defaults();

    send(1, 6, 1, 2, acc);
    at_cycle(acc + 1); chk("reconf_ready", 32'(cfg_ready), 0);
                       chk("reconf_locked", 32'(locked), 1);
    at_cycle(acc + 2); chk("align_locked", 32'(locked), 0);
                       chk("align_out", 32'(outclk), 0);
    at_cycle(acc + 4); chk("realign_a", 32'(outclk), 32'h1);
    at_cycle(acc + 5); chk("realign_b", 32'(outclk), 32'h5);
    at_cycle(acc + 6); chk("realign_c", 32'(outclk), 32'h6);

    // Request held through SETTLE: accepted only on the first LOCKED cycle.
    send(0, 5, 2, 0, acc2);
    chk("held_accept_cycle", 32'(acc2), 32'(acc + 2 + LC));

    send(0, 1, 1, 0, a); at_cycle(a + 1); chk("err_div1", 32'(cfg_err), 1);
    chk("err_div1_locked", 32'(locked), 1);
    send(0, 4, 0, 0, a); at_cycle(a + 1); chk("err_high0", 32'(cfg_err), 1);
    send(3, 4, 2, 0, a); at_cycle(a + 1); chk("err_chan3", 32'(cfg_err), 1);
    chk("err_chan3_locked", 32'(locked), 1);

    for (int n = 0; n < 14; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        ch = $urandom_range(0, NC - 1);
        d = $urandom_range(2, 12);
        h = $urandom_range(1, d - 1);
        p = $urandom_range(0, d - 1);
      end else begin
        ch = $urandom_range(0, 3);
        d = $urandom_range(0, 12);
        h = $urandom_range(0, 12);
        p = $urandom_range(0, 12);
      end
      send(ch, d, h, p, a);
      repeat ($urandom_range(0, 40)) @(posedge refclk);
    end

    // Reset asserted mid-SETTLE after a reconfiguration restores defaults.
    send(2, 9, 4, 3, acc);
    at_cycle(acc + 8);
    @(posedge refclk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_outclk", 32'(outclk), 0);
    chk("async_locked", 32'(locked), 0);
    chk("async_ready", 32'(cfg_ready), 0);
    repeat (3) @(negedge refclk);
    #1 rst_n = 1'b1;
    pin_defaults();
    repeat (40) @(posedge refclk);

    @(negedge refclk); #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
